// File: rtl/vx_warp_ibuffer.sv
// Per-warp instruction buffer: round-robin pops into a registered output, 2-cycle push-to-valid latency.
// Output holds while out_valid && !out_ready; in_ready drops only when the target warp FIFO is full.
module vx_warp_ibuffer #(
  parameter int NUM_WARPS = 4,
  parameter int DEPTH     = 2,
  parameter int DATAW     = 128,
  parameter int NW_BITS   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [NW_BITS-1:0]   in_wid,
  input  logic [DATAW-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [NW_BITS-1:0]   out_wid,
  output logic [DATAW-1:0]     out_data,
  output logic [NW_BITS-1:0]   out_wid_n,
  output logic [DATAW-1:0]     out_data_n,
  input  logic                 out_ready,
  output logic [NUM_WARPS-1:0] empty_mask
);

  localparam int CNTW = $clog2(DEPTH + 1);
  localparam int PTRW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [CNTW-1:0]    count_q  [NUM_WARPS];
  logic [CNTW-1:0]    count_d  [NUM_WARPS];
  logic [PTRW-1:0]    wr_ptr_q [NUM_WARPS];
  logic [PTRW-1:0]    wr_ptr_d [NUM_WARPS];
  logic [PTRW-1:0]    rd_ptr_q [NUM_WARPS];
  logic [PTRW-1:0]    rd_ptr_d [NUM_WARPS];
  logic [DATAW-1:0]   ram_q    [NUM_WARPS][DEPTH];

  logic               out_valid_q;
  logic [NW_BITS-1:0] out_wid_q;
  logic [DATAW-1:0]   out_data_q;
  logic [NW_BITS-1:0] last_grant_q;

  logic               push;
  logic               load;
  logic               pop;
  logic               grant_found;
  logic [NW_BITS-1:0] grant_wid;

  function automatic logic [NW_BITS-1:0] wrap_wid(input int v);
    return NW_BITS'(v % NUM_WARPS);
  endfunction

  // Pointers wrap at DEPTH explicitly so non-power-of-2 depths work.
  function automatic logic [PTRW-1:0] next_ptr(input logic [PTRW-1:0] p);
    return (p == PTRW'(DEPTH - 1)) ? '0 : p + PTRW'(1);
  endfunction

  assign in_ready = (count_q[in_wid] != CNTW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign load     = !out_valid_q || out_ready;
  assign pop      = load && grant_found;

  always_comb begin
    grant_found = 1'b0;
    grant_wid   = '0;
    for (int i = 1; i <= NUM_WARPS; i++) begin
      if (!grant_found && (count_q[wrap_wid(int'(last_grant_q) + i)] != '0)) begin
        grant_found = 1'b1;
        grant_wid   = wrap_wid(int'(last_grant_q) + i);
      end
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      count_d[w]  = count_q[w];
      wr_ptr_d[w] = wr_ptr_q[w];
      rd_ptr_d[w] = rd_ptr_q[w];
      if (push && (in_wid == NW_BITS'(w))) begin
        wr_ptr_d[w] = next_ptr(wr_ptr_q[w]);
      end
      if (pop && (grant_wid == NW_BITS'(w))) begin
        rd_ptr_d[w] = next_ptr(rd_ptr_q[w]);
      end
      if ((push && (in_wid == NW_BITS'(w))) && !(pop && (grant_wid == NW_BITS'(w)))) begin
        count_d[w] = count_q[w] + CNTW'(1);
      end else if (!(push && (in_wid == NW_BITS'(w))) && (pop && (grant_wid == NW_BITS'(w)))) begin
        count_d[w] = count_q[w] - CNTW'(1);
      end
    end
  end

  assign out_wid_n  = pop ? grant_wid : out_wid_q;
  assign out_data_n = pop ? ram_q[grant_wid][rd_ptr_q[grant_wid]] : out_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count_q[w]  <= '0;
        wr_ptr_q[w] <= '0;
        rd_ptr_q[w] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_wid_q    <= '0;
      out_data_q   <= '0;
      last_grant_q <= NW_BITS'(NUM_WARPS - 1);
    end else begin
      for (int w = 0; w < NUM_WARPS; w++) begin
        count_q[w]  <= count_d[w];
        wr_ptr_q[w] <= wr_ptr_d[w];
        rd_ptr_q[w] <= rd_ptr_d[w];
      end
      if (load) begin
        out_valid_q <= grant_found;
      end
      if (pop) begin
        last_grant_q <= grant_wid;
      end
      out_wid_q  <= out_wid_n;
      out_data_q <= out_data_n;
    end
  end

  // Storage is deliberately left out of reset; entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      ram_q[in_wid][wr_ptr_q[in_wid]] <= in_data;
    end
  end

  always_comb begin
    for (int w = 0; w < NUM_WARPS; w++) begin
      empty_mask[w] = (count_q[w] == '0);
    end
  end

  assign out_valid = out_valid_q;
  assign out_wid   = out_wid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_vx_warp_ibuffer.sv
// Bench for vx_warp_ibuffer: queue-based reference model checked every negedge plus directed literal checks.
module tb_vx_warp_ibuffer;

  localparam int NW    = 4;
  localparam int DEPTH = 2;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [1:0]   in_wid;
  logic [127:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [1:0]   out_wid;
  logic [127:0] out_data;
  logic [1:0]   out_wid_n;
  logic [127:0] out_data_n;
  logic         out_ready;
  logic [3:0]   empty_mask;

  int n_chk  = 0;
  int n_pass = 0;

  vx_warp_ibuffer #(.NUM_WARPS(NW), .DEPTH(DEPTH), .DATAW(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_wid     (in_wid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_wid    (out_wid),
    .out_data   (out_data),
    .out_wid_n  (out_wid_n),
    .out_data_n (out_data_n),
    .out_ready  (out_ready),
    .empty_mask (empty_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: one program-order queue per warp and the presented instruction.
  logic [127:0] mq [NW][$];
  logic         m_ov;
  logic [1:0]   m_wid;
  logic [127:0] m_data;
  int           m_lg;

  function automatic int model_grant();
    for (int i = 1; i <= NW; i++) begin
      if (mq[(m_lg + i) % NW].size() > 0) return (m_lg + i) % NW;
    end
    return -1;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit do_push;
    int g;
    if (!reset) begin
      for (int w = 0; w < NW; w++) mq[w].delete();
      m_ov = 1'b0; m_wid = 2'd0; m_data = '0; m_lg = NW - 1;
    end else begin
      do_push = in_valid && (mq[in_wid].size() < DEPTH);
      if (!m_ov || out_ready) begin
        g = model_grant();
        if (g >= 0) begin
          m_ov = 1'b1; m_wid = 2'(g); m_data = mq[g].pop_front(); m_lg = g;
        end else begin
          m_ov = 1'b0;
        end
      end
      if (do_push) mq[in_wid].push_back(in_data);
    end
  end

  always @(negedge clk) begin : cmp
    int g;
    logic [3:0] em;
    g = (!m_ov || out_ready) ? model_grant() : -1;
    for (int w = 0; w < NW; w++) em[w] = (mq[w].size() == 0);
    chk("m_out_valid", out_valid, m_ov);
    chk("m_out_wid", out_wid, m_wid);
    chk("m_out_data", out_data, m_data);
    chk("m_in_ready", in_ready, mq[in_wid].size() < DEPTH);
    chk("m_empty_mask", empty_mask, em);
    chk("m_out_wid_n", out_wid_n, (g >= 0) ? 2'(g) : m_wid);
    chk("m_out_data_n", out_data_n, (g >= 0) ? mq[g][0] : m_data);
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic push_cyc(input logic [1:0] w, input logic [127:0] d);
    in_valid = 1'b1; in_wid = w; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_chk %0d", n_chk);
    $fatal(1, "timeout");
  end

  logic [127:0] issued [$];
  logic [127:0] exp_order [9];

  initial begin : stim
    reset = 1'b0; in_valid = 1'b0; in_wid = 2'd0; in_data = '0; out_ready = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_empty_mask", empty_mask, 4'b1111);
    chk("rst_in_ready", in_ready, 1'b1);
    tick();
    chk("rst_out_data", out_data, '0);
    reset = 1'b1;

    // Single instruction latency
    out_ready = 1'b1;
    push_cyc(2'd0, 128'h11);
    chk("t1_valid_n1", out_valid, 1'b0);
    chk("t1_mask_n1", empty_mask, 4'b1110);
    tick();
    chk("t1_valid_n2", out_valid, 1'b1);
    chk("t1_wid", out_wid, 2'd0);
    chk("t1_data", out_data, 128'h11);
    chk("t1_mask_n2", empty_mask, 4'b1111);
    tick();
    chk("t1_valid_n3", out_valid, 1'b0);

    // Full warp FIFO with output stalled
    do_reset();
    out_ready = 1'b0;
    push_cyc(2'd1, 128'hB0);
    push_cyc(2'd1, 128'hB1);
    push_cyc(2'd1, 128'hB2);
    in_valid = 1'b1; in_wid = 2'd1; in_data = 128'hB3;
    #1;
    chk("t2_full_ready", in_ready, 1'b0);
    chk("t2_hold_data", out_data, 128'hB0);
    tick();
    chk("t2_still_full", in_ready, 1'b0);
    chk("t2_still_b0", out_data, 128'hB0);
    out_ready = 1'b1;
    #1;
    chk("t2_ready_indep", in_ready, 1'b0);
    tick();
    chk("t2_ready_back", in_ready, 1'b1);
    chk("t2_b1", out_data, 128'hB1);
    tick();
    in_valid = 1'b0;
    chk("t2_b2", out_data, 128'hB2);
    tick();
    chk("t2_b3", out_data, 128'hB3);
    tick();
    chk("t2_drained", out_valid, 1'b0);

    // Round-robin order
    do_reset();
    out_ready = 1'b0;
    push_cyc(2'd0, 128'hA0);
    push_cyc(2'd0, 128'hA1);
    push_cyc(2'd2, 128'hC0);
    push_cyc(2'd3, 128'hD0);
    chk("t3_a0", out_data, 128'hA0);
    out_ready = 1'b1;
    tick();
    chk("t3_c0", out_data, 128'hC0);
    chk("t3_c0_wid", out_wid, 2'd2);
    tick();
    chk("t3_d0", out_data, 128'hD0);
    chk("t3_d0_wid", out_wid, 2'd3);
    tick();
    chk("t3_a1", out_data, 128'hA1);
    chk("t3_a1_wid", out_wid, 2'd0);
    tick();
    chk("t3_done", out_valid, 1'b0);

    // Same-warp push and pop every cycle
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1; in_wid = 2'd1; in_data = 128'h400;
    tick();
    for (int k = 1; k <= 10; k++) begin
      in_data = 128'h400 + 128'(k);
      tick();
      chk("t4_data", out_data, 128'h400 + 128'(k - 1));
      chk("t4_w1_nonempty", empty_mask[1], 1'b0);
    end
    in_valid = 1'b0;
    tick();
    chk("t4_last", out_data, 128'h40A);
    tick();
    chk("t4_done", out_valid, 1'b0);

    // Toggling backpressure with all warps full
    do_reset();
    out_ready = 1'b0;
    for (int w = 0; w < NW; w++) begin
      for (int i = 0; i < ((w == 0) ? 3 : 2); i++) push_cyc(2'(w), 128'h500 + 128'(w * 16 + i));
    end
    chk("t5_full_mask", empty_mask, 4'b0000);
    exp_order[0] = 128'h500; exp_order[1] = 128'h510; exp_order[2] = 128'h520;
    exp_order[3] = 128'h530; exp_order[4] = 128'h501; exp_order[5] = 128'h511;
    exp_order[6] = 128'h521; exp_order[7] = 128'h531; exp_order[8] = 128'h502;
    issued.delete();
    for (int c = 0; c < 24; c++) begin
      out_ready = (c % 2 == 0);
      #1;
      if (out_valid && out_ready) issued.push_back(out_data);
      tick();
    end
    chk("t5_count", 128'(issued.size()), 128'd9);
    for (int i = 0; i < 9; i++) begin
      if (i < issued.size()) chk("t5_order", issued[i], exp_order[i]);
    end

    // Reset in the middle of traffic
    do_reset();
    out_ready = 1'b0;
    push_cyc(2'd0, 128'h60);
    push_cyc(2'd0, 128'h61);
    push_cyc(2'd0, 128'h62);
    push_cyc(2'd1, 128'h63);
    push_cyc(2'd1, 128'h64);
    push_cyc(2'd2, 128'h65);
    chk("t6_pre_mask", empty_mask, 4'b1000);
    reset = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_mask", empty_mask, 4'b1111);
    chk("t6_rst_ready", in_ready, 1'b1);
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    push_cyc(2'd0, 128'h66);
    chk("t6_n1_valid", out_valid, 1'b0);
    tick();
    chk("t6_n2_valid", out_valid, 1'b1);
    chk("t6_n2_wid", out_wid, 2'd0);
    chk("t6_n2_data", out_data, 128'h66);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
